// File: rtl/seq_alu.sv
// seq_alu: multi-cycle unsigned ALU (add, sub, shift-add mul, restoring div)
// with a start/busy/done handshake and registered results and status flags.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [1:0]       ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_hi,
    output logic             ovf,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // One shift-add step: acc = {partial product high, remaining multiplier}.
    // The multiplier bit consumed is acc[0]; the whole register shifts right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // One restoring-division step: acc = {remainder, dividend/quotient}.
    // The next dividend bit shifts into the remainder, the quotient bit shifts in at the LSB.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   dvsr);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr};
        if (!diff[WIDTH]) begin
            return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     o_q, o_d;
    logic [WIDTH-1:0]     o_hi_q, o_hi_d;
    logic                 ovf_q, ovf_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH:0]       add_full;
    logic [WIDTH-1:0]     sub_diff;

    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff = a_q - b_q;

    // Next-state, datapath iteration and result write-back.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        done_d     = 1'b0;
        o_d        = o_q;
        o_hi_d     = o_hi_q;
        ovf_d      = ovf_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = i1;
                    b_d   = i2;
                    op_d  = ctrl;
                    cnt_d = '0;
                    // Multiplier (mul) or dividend (div) preloads the low half.
                    acc_d = {{WIDTH{1'b0}}, (ctrl == OP_MUL) ? i2 : i1};
                    if (ctrl == OP_MUL || (ctrl == OP_DIV && i2 != '0)) begin
                        state_d = S_CALC;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_CALC: begin
                acc_d = (op_q == OP_MUL) ? mul_step(acc_q, a_q) : div_step(acc_q, b_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d     = 1'b1;
                state_d    = S_IDLE;
                div_zero_d = 1'b0;
                ovf_d      = 1'b0;
                o_hi_d     = '0;
                case (op_q)
                    OP_ADD: begin
                        o_d   = add_full[WIDTH-1:0];
                        ovf_d = add_full[WIDTH];
                    end
                    OP_SUB: begin
                        o_d   = sub_diff;
                        ovf_d = (a_q < b_q);
                    end
                    OP_MUL: begin
                        o_d    = acc_q[WIDTH-1:0];
                        o_hi_d = acc_q[2*WIDTH-1:WIDTH];
                        ovf_d  = |acc_q[2*WIDTH-1:WIDTH];
                    end
                    default: begin
                        if (b_q == '0) begin
                            o_d        = '1;
                            o_hi_d     = a_q;
                            div_zero_d = 1'b1;
                        end else begin
                            o_d    = acc_q[WIDTH-1:0];
                            o_hi_d = acc_q[2*WIDTH-1:WIDTH];
                        end
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; operand/accumulator registers carry no reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        op_q  <= op_d;
        acc_q <= acc_d;
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            o_q        <= '0;
            o_hi_q     <= '0;
            ovf_q      <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            o_q        <= o_d;
            o_hi_q     <= o_hi_d;
            ovf_q      <= ovf_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign o        = o_q;
    assign o_hi     = o_hi_q;
    assign ovf      = ovf_q;
    assign div_zero = div_zero_q;

endmodule
